mem_stage: RTL

//   Memory-access stage downstream of alu_stage, upstream of register-bank writeback.

---
 rtl/mem_stage.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between the ALU stage and register writeback.
//   Non-memory instructions retire one cycle after acceptance. Loads and stores hold a
//   req/ack transaction to data memory, stalling upstream until ack or timeout.
// Ports:
//   clk_i, rst_i (async active-low)
//   upstream : valid_i, ready_o, is_load_i, is_store_i, alu_result_i, store_data_i,
//              reg_wr_en_i, wr_reg_i
//   memory   : mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_ack_i, mem_rdata_i
//   writeback: wb_valid_o, wb_reg_wr_en_o, wb_wr_reg_o, wb_data_o
//   status   : error_o (sticky timeout flag)
module mem_stage #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned REGISTER_WIDTH = 5,
    parameter int unsigned TIMEOUT        = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic                      is_load_i,
    input  logic                      is_store_i,
    input  logic [DATA_WIDTH-1:0]     alu_result_i,
    input  logic [DATA_WIDTH-1:0]     store_data_i,
    input  logic                      reg_wr_en_i,
    input  logic [REGISTER_WIDTH-1:0] wr_reg_i,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [ADDR_WIDTH-1:0]     mem_addr_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    input  logic                      mem_ack_i,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
    output logic                      wb_valid_o,
    output logic                      wb_reg_wr_en_o,
    output logic [REGISTER_WIDTH-1:0] wb_wr_reg_o,
    output logic [DATA_WIDTH-1:0]     wb_data_o,
    output logic                      error_o
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      ld_wr_en_q, ld_wr_en_d;
    logic [REGISTER_WIDTH-1:0] dest_q, dest_d;

    logic                      req_d, we_d;
    logic [ADDR_WIDTH-1:0]     addr_d;
    logic [DATA_WIDTH-1:0]     wdata_d;
    logic                      wb_valid_d, wb_wr_en_d, error_d;
    logic [REGISTER_WIDTH-1:0] wb_reg_d;
    logic [DATA_WIDTH-1:0]     wb_data_d;

    logic accept;
    logic is_mem;

    assign ready_o = (state_q == ST_IDLE);
    assign accept  = valid_i & ready_o;
    assign is_mem  = is_load_i | is_store_i;

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ld_wr_en_d = ld_wr_en_q;
        dest_d     = dest_q;
        req_d      = mem_req_o;
        we_d       = mem_we_o;
        addr_d     = mem_addr_o;
        wdata_d    = mem_wdata_o;
        wb_valid_d = 1'b0;
        wb_wr_en_d = wb_reg_wr_en_o;
        wb_reg_d   = wb_wr_reg_o;
        wb_data_d  = wb_data_o;
        error_d    = error_o;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_mem) begin
                        state_d    = ST_WAIT;
                        cnt_d      = '0;
                        req_d      = 1'b1;
                        // Load wins when both flags are set
                        we_d       = is_store_i & ~is_load_i;
                        addr_d     = alu_result_i[ADDR_WIDTH-1:0];
                        wdata_d    = store_data_i;
                        dest_d     = wr_reg_i;
                        ld_wr_en_d = reg_wr_en_i;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_wr_en_d = reg_wr_en_i;
                        wb_reg_d   = wr_reg_i;
                        wb_data_d  = alu_result_i;
                    end
                end
            end
            ST_WAIT: begin
                // Ack takes priority over an expiring counter
                if (mem_ack_i) begin
                    state_d    = ST_IDLE;
                    req_d      = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_reg_d   = dest_q;
                    if (mem_we_o) begin
                        wb_wr_en_d = 1'b0;
                        wb_data_d  = DATA_WIDTH'(mem_addr_o);
                    end else begin
                        wb_wr_en_d = ld_wr_en_q;
                        wb_data_d  = mem_rdata_i;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d    = ST_IDLE;
                    req_d      = 1'b0;
                    error_d    = 1'b1;
                    wb_valid_d = 1'b1;
                    wb_wr_en_d = 1'b0;
                    wb_reg_d   = dest_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            ld_wr_en_q     <= 1'b0;
            dest_q         <= '0;
            mem_req_o      <= 1'b0;
            mem_we_o       <= 1'b0;
            mem_addr_o     <= '0;
            mem_wdata_o    <= '0;
            wb_valid_o     <= 1'b0;
            wb_reg_wr_en_o <= 1'b0;
            wb_wr_reg_o    <= '0;
            wb_data_o      <= '0;
            error_o        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            ld_wr_en_q     <= ld_wr_en_d;
            dest_q         <= dest_d;
            mem_req_o      <= req_d;
            mem_we_o       <= we_d;
            mem_addr_o     <= addr_d;
            mem_wdata_o    <= wdata_d;
            wb_valid_o     <= wb_valid_d;
            wb_reg_wr_en_o <= wb_wr_en_d;
            wb_wr_reg_o    <= wb_reg_d;
            wb_data_o      <= wb_data_d;
            error_o        <= error_d;
        end
    end

endmodule
